// File: rtl/uart_pkg.sv
// Shared 8N1 frame definitions for the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the serial line, reset to idle, with falling-edge detect.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] real_q, real_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;

    // real_q tracks when sync_q's last stage holds a true line sample rather than
    // the reset fill; edges are only armed after a genuine high has been seen.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        real_d  = {real_q[SYNC_STAGES-2:0], 1'b1};
        prev_d  = sync_q[SYNC_STAGES-1];
        armed_d = armed_q | (real_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1]);
    end

    // Synchroniser and edge-detect state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{IDLE_LVL}};
            real_q  <= '0;
            prev_q  <= IDLE_LVL;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            real_q  <= real_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = armed_q & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit 3-sample majority vote, glitch rejection,
// framing and overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 87,
    parameter int sync_stages = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] CNT_LAST = 16'(clk_per_bit - 1);
    localparam logic [15:0] SAMP_MID = 16'(clk_per_bit / 2);
    localparam logic [15:0] SAMP_A   = SAMP_MID - 16'd1;
    localparam logic [15:0] SAMP_C   = SAMP_MID + 16'd1;

    uart_state_e state_q, state_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        unread_q, unread_d;
    logic        busy_q, busy_d;
    logic        rxs_s, fall_s, vote_s, cnt_last_s, vote_pt_s;

    uart_rx_sync #(.SYNC_STAGES(sync_stages)) u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rxs   (rxs_s),
        .fall  (fall_s)
    );

    assign cnt_last_s = (clk_count_q == CNT_LAST);
    assign vote_pt_s  = (clk_count_q == SAMP_C);
    assign vote_s     = maj3(samp_q[0], samp_q[1], rxs_s);

    // Next-state, sampling and output decode; the third sample is taken live at SAMP_C.
    always_comb begin
        state_d     = state_q;
        clk_count_d = cnt_last_s ? 16'd0 : clk_count_q + 16'd1;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        data_out_d  = data_out_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        unread_d    = rx_ack ? 1'b0 : unread_q;

        if (clk_count_q == SAMP_A) begin
            samp_d[0] = rxs_s;
        end else if (clk_count_q == SAMP_MID) begin
            samp_d[1] = rxs_s;
        end else begin
            samp_d = samp_q;
        end

        case (state_q)
            IDLE: begin
                clk_count_d = 16'd0;
                bit_index_d = 3'd0;
                state_d     = fall_s ? START : IDLE;
            end
            START: begin
                if (vote_pt_s && (vote_s != START_LVL)) begin
                    state_d = IDLE;
                end else if (cnt_last_s) begin
                    state_d     = DATA;
                    bit_index_d = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (vote_pt_s) begin
                    shift_d[bit_index_q] = vote_s;
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_last_s) begin
                    if (bit_index_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                // Decide at the vote so a following start edge is not missed.
                if (vote_pt_s) begin
                    if (vote_s == STOP_LVL) begin
                        data_out_d = shift_q;
                        rx_valid_d = 1'b1;
                        overrun_d  = unread_q & ~rx_ack;
                        unread_d   = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK_WAIT;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            BREAK_WAIT: begin
                clk_count_d = 16'd0;
                state_d     = rxs_s ? IDLE : BREAK_WAIT;
            end
            default: begin
                state_d     = IDLE;
                clk_count_d = 16'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_count_q <= 16'd0;
            bit_index_q <= 3'd0;
            shift_q     <= 8'h00;
            samp_q      <= 2'b00;
            data_out_q  <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            unread_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            data_out_q  <= data_out_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            unread_q    <= unread_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_out_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
